// File: rtl/pcm_to_i2s.sv
// pcm_to_i2s: PCM sample-pair to I2S serializer with a one-deep holding register.
// sck is divided from clk; ws/sd update on the same clk edge as each sck fall.
module pcm_to_i2s #(
    parameter int NUMBER_OF_BITS = 8,
    parameter int SLOT_BITS = 16,
    parameter int SCK_DIV = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUMBER_OF_BITS-1:0] in_left,
    input  logic [NUMBER_OF_BITS-1:0] in_right,
    output logic                      sck,
    output logic                      ws,
    output logic                      sd,
    output logic                      underrun
);
    localparam int CW = $clog2(2*SLOT_BITS);
    localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;

    logic [DW-1:0]             div;
    logic [CW-1:0]             c, c_nx, p;
    logic [NUMBER_OF_BITS-1:0] hold_l, hold_r, frame_l, frame_r, word, sh;
    logic                      hold_valid, accept, start, half, tick, load, bit_nx;

    assign in_ready = !hold_valid;
    assign accept   = in_valid && !hold_valid;
    assign c_nx     = (c == CW'(2*SLOT_BITS-1)) ? '0 : c + 1'b1;
    assign p        = (c_nx >= CW'(SLOT_BITS)) ? c_nx - CW'(SLOT_BITS) : c_nx;
    assign word     = (c_nx >= CW'(SLOT_BITS)) ? frame_r : frame_l;
    assign sh       = word << (p - CW'(1));
    assign bit_nx   = (p != '0 && p <= CW'(NUMBER_OF_BITS)) ? sh[NUMBER_OF_BITS-1] : 1'b0;
    assign load     = start || (tick && c_nx == '0);

    always_comb begin
        state_nx = state;
        start    = 1'b0;
        half     = 1'b0;
        tick     = 1'b0;
        if (!en)
            state_nx = IDLE;
        else if (state == IDLE) begin
            state_nx = RUN;
            start    = 1'b1;
        end else begin
            half = div == DW'(SCK_DIV-1);
            tick = half && sck;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div        <= '0;
            sck        <= 1'b0;
            c          <= '0;
            ws         <= 1'b0;
            sd         <= 1'b0;
            underrun   <= 1'b0;
            hold_valid <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
            frame_l    <= '0;
            frame_r    <= '0;
        end else begin
            underrun <= load && !hold_valid;
            if (load) begin
                frame_l <= hold_valid ? hold_l : '0;
                frame_r <= hold_valid ? hold_r : '0;
            end
            // a pair accepted on a load edge with an empty hold waits for the next frame
            if (load && hold_valid)
                hold_valid <= 1'b0;
            else if (accept) begin
                hold_valid <= 1'b1;
                hold_l     <= in_left;
                hold_r     <= in_right;
            end
            if (state_nx == IDLE || start) begin
                div <= '0;
                sck <= 1'b0;
                c   <= '0;
                ws  <= 1'b0;
                sd  <= 1'b0;
            end else if (half) begin
                div <= '0;
                sck <= !sck;
                if (tick) begin
                    c  <= c_nx;
                    ws <= c_nx >= CW'(SLOT_BITS);
                    sd <= bit_nx;
                end
            end else
                div <= div + 1'b1;
        end
    end
endmodule

// File: tb/tb_pcm_to_i2s.sv
// tb_pcm_to_i2s: frame-level model feeds a scoreboard of expected L/R words,
// a deserializer on the I2S lines pops and compares; tasks add directed checks.
`timescale 1ns/1ps
module tb_pcm_to_i2s;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       en = 1'b0, in_valid = 1'b0;
    logic [7:0] in_left = 8'h00, in_right = 8'h00;
    logic       in_ready, sck, ws, sd, underrun;
    logic       en3 = 1'b0, in_valid3 = 1'b0;
    logic [7:0] zero8 = 8'h00;
    logic       in_ready3, sck3, ws3, sd3, underrun3;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    pcm_to_i2s dut (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
        .in_left(in_left), .in_right(in_right), .sck(sck), .ws(ws), .sd(sd), .underrun(underrun)
    );

    pcm_to_i2s #(.NUMBER_OF_BITS(8), .SLOT_BITS(16), .SCK_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en3), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_left(zero8), .in_right(zero8), .sck(sck3), .ws(ws3), .sd(sd3), .underrun(underrun3)
    );

    // frame-level model of the SCK_DIV=1 instance: 64 clk per frame, load at frame cycle 0
    logic        m_run = 1'b0, m_hv = 1'b0, m_under = 1'b0, m_load, m_acc;
    logic [7:0]  m_hl = 8'h00, m_hr = 8'h00;
    int          m_cyc = 0;
    logic [15:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 1'b0; m_cyc = 0; m_hv = 1'b0; m_hl = 8'h00; m_hr = 8'h00; m_under = 1'b0;
            exp_q.delete();
        end else begin
            m_acc   = in_valid && !m_hv;
            m_load  = en && (!m_run || m_cyc == 63);
            m_under = m_load && !m_hv;
            if (m_load) exp_q.push_back(m_hv ? {m_hl, m_hr} : 16'h0000);
            if (m_load && m_hv) m_hv = 1'b0;
            else if (m_acc) begin m_hv = 1'b1; m_hl = in_left; m_hr = in_right; end
            if (!en) begin m_run = 1'b0; m_cyc = 0; exp_q.delete(); end
            else if (!m_run) begin m_run = 1'b1; m_cyc = 0; end
            else m_cyc = (m_cyc + 1) % 64;
        end
    end

    // receiver: samples sd on sck rises, rebuilds both words, compares against the scoreboard
    int          k = 0, mon_p;
    logic        prev_sck = 1'b0;
    logic [7:0]  sh8 = 8'h00, got_l = 8'h00;
    logic [15:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            k = 0; prev_sck = 1'b0;
        end else begin
            checks++;
            if (in_ready !== !m_hv) begin errors++; $display("FAIL in_ready: got %b exp %b t=%0t", in_ready, !m_hv, $time); end
            checks++;
            if (underrun !== m_under) begin errors++; $display("FAIL underrun: got %b exp %b t=%0t", underrun, m_under, $time); end
            if (!m_run) begin
                checks++;
                if ({sck, ws, sd} !== 3'b000) begin errors++; $display("FAIL idle_lines: got %b exp 000 t=%0t", {sck, ws, sd}, $time); end
                k = 0; prev_sck = 1'b0;
            end else begin
                checks++;
                if (sck !== (m_cyc % 2 == 1)) begin errors++; $display("FAIL sck: got %b at frame cycle %0d t=%0t", sck, m_cyc, $time); end
                checks++;
                if (ws !== (m_cyc >= 32)) begin errors++; $display("FAIL ws: got %b at frame cycle %0d t=%0t", ws, m_cyc, $time); end
                if (sck && !prev_sck) begin
                    mon_p = k % 16;
                    if (mon_p >= 1 && mon_p <= 8) sh8 = {sh8[6:0], sd};
                    else begin
                        checks++;
                        if (sd !== 1'b0) begin errors++; $display("FAIL sd_pad: got %b exp 0 at bit %0d t=%0t", sd, k, $time); end
                    end
                    if (k == 8) got_l = sh8;
                    if (k == 24) begin
                        checks++;
                        if (exp_q.size() == 0) begin errors++; $display("FAIL frame: got %h with nothing expected", {got_l, sh8}); end
                        else begin
                            e = exp_q.pop_front();
                            if ({got_l, sh8} !== e) begin errors++; $display("FAIL frame: got %h exp %h t=%0t", {got_l, sh8}, e, $time); end
                        end
                    end
                    k = (k + 1) % 32;
                end
                prev_sck = sck;
            end
        end
    end

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({sck, ws, sd, underrun, in_ready} !== 5'b00001) begin errors++; $display("FAIL reset: got %b exp 00001", {sck, ws, sd, underrun, in_ready}); end
        checks++;
        if ({sck3, ws3, sd3, underrun3, in_ready3} !== 5'b00001) begin errors++; $display("FAIL reset3: got %b exp 00001", {sck3, ws3, sd3, underrun3, in_ready3}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pattern;
        logic [31:0] exp_bits;
        exp_bits = 32'h5280_1E00;
        in_valid = 1'b1; in_left = 8'hA5; in_right = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0; en = 1'b1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL pattern_held: got %b exp 0", in_ready); end
        @(negedge clk);
        for (int c = 0; c < 32; c++) begin
            if (c > 0) repeat (2) @(negedge clk);
            checks++;
            if (sd !== exp_bits[31-c] || ws !== (c >= 16)) begin
                errors++; $display("FAIL pattern c=%0d: got sd=%b ws=%b exp sd=%b ws=%b", c, sd, ws, exp_bits[31-c], c >= 16);
            end
        end
        repeat (40) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_underrun;
        int n_u, n_sd;
        n_u = 0; n_sd = 0;
        en = 1'b1;
        repeat (192) begin
            @(negedge clk);
            n_u += int'(underrun);
            n_sd += int'(sd);
        end
        en = 1'b0;
        checks++;
        if (n_u != 3) begin errors++; $display("FAIL underrun_count: got %0d exp 3", n_u); end
        checks++;
        if (n_sd != 0) begin errors++; $display("FAIL underrun_sd: got %0d ones exp 0", n_sd); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [7:0] d;
        logic       was_ready;
        int         n_acc;
        d = 8'h10; n_acc = 0;
        in_left = d; in_right = ~d; in_valid = 1'b1; en = 1'b1;
        was_ready = in_ready;
        repeat (672) begin
            @(negedge clk);
            if (was_ready) begin n_acc++; d++; in_left = d; in_right = ~d; end
            was_ready = in_ready;
        end
        in_valid = 1'b0; en = 1'b0;
        checks++;
        if (n_acc != 11) begin errors++; $display("FAIL back_to_back_accepts: got %0d exp 11", n_acc); end
        @(negedge clk);
    endtask

    task automatic test_disable;
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL disable_first_load: got underrun %b exp 0", underrun); end
        in_valid = 1'b1; in_left = 8'hC3; in_right = 8'h96;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({sck, ws} !== 2'b10) begin errors++; $display("FAIL disable_pre: got sck,ws=%b exp 10", {sck, ws}); end
        en = 1'b0;
        @(negedge clk);
        checks++;
        if ({sck, ws, sd} !== 3'b000) begin errors++; $display("FAIL disable_lines: got %b exp 000", {sck, ws, sd}); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL disable_hold_kept: got in_ready %b exp 0", in_ready); end
        repeat (3) @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        checks++;
        if (underrun !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reenable_load: got underrun=%b in_ready=%b exp 0 1", underrun, in_ready);
        end
        repeat (60) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        en = 1'b1; en3 = 1'b1;
        in_valid = 1'b1; in_left = 8'h5A; in_right = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (21) @(negedge clk);
        checks++;
        if ({sck, in_ready} !== 2'b10) begin errors++; $display("FAIL reset_mid_pre: got sck,in_ready=%b exp 10", {sck, in_ready}); end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({sck, ws, sd, underrun, in_ready} !== 5'b00001) begin errors++; $display("FAIL reset_mid: got %b exp 00001", {sck, ws, sd, underrun, in_ready}); end
        checks++;
        if ({sck3, ws3, sd3, underrun3, in_ready3} !== 5'b00001) begin errors++; $display("FAIL reset_mid3: got %b exp 00001", {sck3, ws3, sd3, underrun3, in_ready3}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL reset_mid_underrun: got %b exp 1", underrun); end
        repeat (64) @(negedge clk);
        en = 1'b0; en3 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sck_div3;
        logic ps, pw, seen;
        int   run, last, n_rise;
        ps = 1'b0; pw = 1'b0; seen = 1'b0; run = 0; last = -1; n_rise = 0;
        en3 = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (sck3 !== ps) begin
                if (sck3) begin
                    n_rise++;
                    if (seen) begin
                        checks++;
                        if (run != 3) begin errors++; $display("FAIL div3_low: got %0d clk exp 3", run); end
                    end
                    seen = 1'b1;
                end else begin
                    checks++;
                    if (run != 3) begin errors++; $display("FAIL div3_high: got %0d clk exp 3", run); end
                end
                run = 1;
            end else run++;
            if (ws3 !== pw) begin
                checks++;
                if (!(ps && !sck3)) begin errors++; $display("FAIL div3_ws_edge: ws moved with sck %b->%b exp 1->0", ps, sck3); end
                if (ws3) begin
                    if (last >= 0) begin
                        checks++;
                        if (i - last != 192) begin errors++; $display("FAIL div3_frame: got %0d clk exp 192", i - last); end
                    end
                    last = i;
                end
            end
            ps = sck3; pw = ws3;
        end
        en3 = 1'b0;
        checks++;
        if (n_rise < 90) begin errors++; $display("FAIL div3_rises: got %0d exp >= 90", n_rise); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_underrun();
        test_back_to_back();
        test_disable();
        test_reset_mid();
        test_sck_div3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pcm_to_i2s.md
PCM_TO_I2S -- requirements
Module: pcm_to_i2s

Interface
REQ-001 SHALL have parameter NUMBER_OF_BITS, default 8: PCM word width per channel.
REQ-002 SHALL have parameter SLOT_BITS, default 16: SCK periods per channel slot; legal only when SLOT_BITS >= NUMBER_OF_BITS+1.
REQ-003 SHALL have parameter SCK_DIV, default 1: clk cycles per SCK half-period; legal when >= 1.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  system clock, all logic on posedge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 en  in  1  transmitter enable.
REQ-007 in_valid  in  1  PCM sample pair offered.
REQ-008 in_ready  out  1  holding register empty; can accept a sample pair.
REQ-009 in_left  in  NUMBER_OF_BITS  left PCM word.
REQ-010 in_right  in  NUMBER_OF_BITS  right PCM word.
REQ-011 sck  out  1  I2S bit clock.
REQ-012 ws  out  1  I2S word select; 0 = left, 1 = right.
REQ-013 sd  out  1  I2S serial data, MSB first.
REQ-014 underrun  out  1  one-clk pulse: frame started with no sample pair held.

Function
REQ-015 SHALL hold one sample pair in a holding register; in_ready = !hold_valid, combinational.
REQ-016 SHALL accept in_left/in_right into the holding register on a clk edge where in_valid && in_ready.
REQ-017 SHALL keep in_left/in_right/in_valid as don't-care when in_ready = 0; no overwrite of held data.
REQ-018 SHALL divide clk: sck toggles every SCK_DIV clk cycles while running; sck starts low; SCK period = 2*SCK_DIV clk.
REQ-019 SHALL keep a frame bit counter c in 0..2*SLOT_BITS-1, incremented on each sck falling edge (tick), wrapping to 0.
REQ-020 SHALL register ws, sd and c on the same clk edge as the tick, so they change only while sck falls.
REQ-021 SHALL drive ws = 0 for c < SLOT_BITS, ws = 1 otherwise.
REQ-022 With p = c mod SLOT_BITS: p = 0 -> sd = 0 (I2S one-bit delay); 1 <= p <= NUMBER_OF_BITS -> sd = word bit NUMBER_OF_BITS-p; p > NUMBER_OF_BITS -> sd = 0.
REQ-023 Word = left frame word while ws = 0, right frame word while ws = 1.
REQ-024 SHALL perform a frame load at the tick wrapping c to 0, and at start.
REQ-025 Frame load: hold_valid = 1 -> frame words = held pair, hold_valid cleared (in_ready = 1 next cycle).
REQ-026 Frame load: hold_valid = 0 -> frame words = 0, underrun pulses high for exactly that one clk cycle.
REQ-027 Accept and frame load on the same edge (hold empty): underrun still pulses; accepted pair stays held for the next frame.
REQ-028 Start: first clk edge with en = 1 while idle -> frame load, c = 0, ws = 0, sd = 0, divider cleared, sck = 0.
REQ-029 Running: first sck rise SCK_DIV clk after start; first tick 2*SCK_DIV clk after start sets c = 1 and sd = left MSB.
REQ-030 en = 0 at any clk edge, including mid-frame: return idle on that edge; sck, ws, sd = 0, c = 0, divider cleared.
REQ-031 Idle: the holding register keeps its contents and the handshake stays active.
REQ-032 SHALL never produce a partial sck pulse shorter than SCK_DIV clk, except when truncated by en = 0 or reset.

Reset
REQ-033 rst_n low SHALL immediately force sck = 0, ws = 0, sd = 0, underrun = 0, c = 0, divider = 0, hold_valid = 0 (in_ready = 1), idle state.
REQ-034 Reset SHALL clear frame words and the held pair to 0.
REQ-035 Reset release SHALL take effect on the next clk edge; a start needs en = 1 at or after that edge.

Verification (NUMBER_OF_BITS = 8, SLOT_BITS = 16, SCK_DIV = 1 unless stated)
REQ-036 Hold 0xA5/0x3C, raise en -> after the start frame, the next 32 ticks give sd = 0,1,0,1,0,0,1,0,1,0*7 then 0,0,0,1,1,1,1,0,0,0*7; ws = 0 for 16 ticks, then 1; ws period 64 clk.
REQ-037 en = 1 with nothing held -> underrun pulses 1 clk at start and at each wrap; sd stays 0; ws still toggles every 32 clk.
REQ-038 in_valid held high with incrementing data -> exactly one pair accepted per frame; in_ready low from accept to the next load; no pair lost or duplicated over 10 frames.
REQ-039 Deassert en at c = 5 -> same edge gives sck = ws = sd = 0; held pair kept; re-enable -> start load uses it with no underrun.
REQ-040 SCK_DIV = 3 -> sck high 3 clk, low 3 clk; ws changes only at sck falling edges; frame length 192 clk.
REQ-041 Assert rst_n low mid-frame with a pair held -> all outputs 0 at once, no clk edge needed; in_ready = 1; after release with en = 1 -> first frame underruns.
